// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRelease,
    StShift,
    StWaitIdle,
    StErr
  } ps2tx_state_t;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrStartTmo = 2'd1,
    ErrFrameTmo = 2'd2,
    ErrNoAck    = 2'd3
  } ps2tx_err_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  // Microseconds to clock cycles; 64-bit product so 15 ms at 28 MHz cannot overflow.
  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned freq_hz);
    logic [63:0] prod;
    prod = 64'(us) * 64'(freq_hz);
    return 32'(prod / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Request/status and pin-control bundle of the PS/2 host transmitter.
// master: the requesting logic plus pad side; slave: the transmitter itself.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       rx_inhibit;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  modport master (
    output tx_valid, tx_data, ps2_clk_in, ps2_dat_in,
    input  tx_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, done, error, err_code
  );

  modport slave (
    input  tx_valid, tx_data, ps2_clk_in, ps2_dat_in,
    output tx_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, done, error, err_code
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one PS/2 line.
// The output only follows the synced input after it has differed for FILT_LEN
// consecutive cycles, so shorter glitches never reach the output.
module ps2_line_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o
);

  localparam int unsigned CntW = $clog2(FILT_LEN + 1);

  logic            sync1_q, sync2_q;
  logic            out_q, out_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synced line disagrees with the output.
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (sync2_q != out_q) begin
      if (cnt_q == CntW'(FILT_LEN - 1)) begin
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and filter state; idle PS/2 lines are high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      out_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_o = out_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Drives the shared clock/data pins
// through open-drain enables; the chip top turns each *_oe into "low or 'z".
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 28_000_000,
  parameter int unsigned INHIBIT_US   = 120,
  parameter int unsigned START_TMO_US = 15000,
  parameter int unsigned FRAME_TMO_US = 2000,
  parameter int unsigned FILT_LEN     = 8
) (
  input  logic          clk28_i,
  input  logic          rst_i,
  ps2_host_tx_if.slave  bus
);

  localparam int unsigned InhCyc   = us_to_cycles(INHIBIT_US, CLK_FREQ);
  localparam int unsigned StartCyc = us_to_cycles(START_TMO_US, CLK_FREQ);
  localparam int unsigned FrameCyc = us_to_cycles(FRAME_TMO_US, CLK_FREQ);
  // One shared saturating counter times inhibit, start and frame phases.
  localparam int unsigned TmoW     = $clog2(StartCyc) + 1;

  ps2tx_state_t    state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic [3:0]      n_q, n_d;
  logic [TmoW-1:0] cnt_q, cnt_d, cnt_inc;
  ps2tx_err_t      err_q, err_d;
  logic            clk_prev_q;

  logic clk_filt, dat_filt, clk_fall;
  logic start_tmo, frame_tmo, inh_last, idle_ok;
  logic [2:0] bit_idx;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_i  (clk28_i),
    .rst_i  (rst_i),
    .line_i (bus.ps2_clk_in),
    .line_o (clk_filt)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk_i  (clk28_i),
    .rst_i  (rst_i),
    .line_i (bus.ps2_dat_in),
    .line_o (dat_filt)
  );

  assign clk_fall  = clk_prev_q & ~clk_filt;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign start_tmo = (cnt_q >= TmoW'(StartCyc - 1));
  assign frame_tmo = (cnt_q >= TmoW'(FrameCyc - 1));
  assign inh_last  = (cnt_q == TmoW'(InhCyc - 1));
  assign idle_ok   = clk_filt & dat_filt;
  assign bit_idx   = 3'(n_q - 4'd1);

  // State and datapath registers.
  always_ff @(posedge clk28_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      data_q     <= '0;
      par_q      <= 1'b0;
      n_q        <= '0;
      cnt_q      <= '0;
      err_q      <= ErrNone;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_q      <= par_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      clk_prev_q <= clk_filt;
    end
  end

  // Next-state: phase sequencing, bit counting on device clock falls, timeouts.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    n_d     = n_q;
    err_d   = err_q;
    cnt_d   = cnt_inc;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.tx_valid) begin
          data_d  = bus.tx_data;
          par_d   = ~^bus.tx_data;
          n_d     = '0;
          err_d   = ErrNone;
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        if (inh_last) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (clk_fall) begin
          n_d     = 4'd1;
          cnt_d   = '0;
          state_d = StShift;
        end else if (start_tmo) begin
          err_d   = ErrStartTmo;
          state_d = StErr;
        end
      end
      StShift: begin
        if (frame_tmo) begin
          err_d   = ErrFrameTmo;
          state_d = StErr;
        end else if (clk_fall) begin
          n_d = n_q + 4'd1;
          // 11th fall: the device acknowledges by holding data low.
          if (n_q == 4'd10) begin
            if (!dat_filt) begin
              state_d = StWaitIdle;
            end else begin
              err_d   = ErrNoAck;
              state_d = StErr;
            end
          end
        end
      end
      StWaitIdle: begin
        if (frame_tmo) begin
          err_d   = ErrFrameTmo;
          state_d = StErr;
        end else if (idle_ok) begin
          state_d = StIdle;
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.ps2_clk_oe = 1'b0;
    bus.ps2_dat_oe = 1'b0;
    bus.done       = 1'b0;
    bus.error      = 1'b0;
    bus.err_code   = 2'd0;
    unique case (state_q)
      StInhibit: begin
        bus.ps2_clk_oe = 1'b1;
        bus.ps2_dat_oe = inh_last;
      end
      StRelease: begin
        bus.ps2_dat_oe = 1'b1;
      end
      StShift: begin
        if (n_q >= 4'd1 && n_q <= 4'd8) begin
          bus.ps2_dat_oe = ~data_q[bit_idx];
        end else if (n_q == 4'd9) begin
          bus.ps2_dat_oe = ~par_q;
        end
      end
      StWaitIdle: begin
        bus.done = idle_ok & ~frame_tmo;
      end
      StErr: begin
        bus.error    = 1'b1;
        bus.err_code = err_q;
      end
      default: begin
      end
    endcase
    bus.tx_ready   = (state_q == StIdle);
    bus.rx_inhibit = (state_q != StIdle);
  end

endmodule
